// File: rtl/ascon_pkg.sv
// Shared definitions for the Wishbone front end of the ASCON block:
// register offsets, register bit positions, bus FSM states and address decode.
package ascon_pkg;

  localparam logic [7:0] OFF_CTRL    = 8'h80;
  localparam logic [7:0] OFF_STATUS  = 8'h84;
  localparam logic [7:0] OFF_DATALEN = 8'h88;

  localparam int CTRL_START = 0;
  localparam int CTRL_IE    = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam logic [7:0] DATALEN_MAX = 8'h80;
  localparam logic [3:0] SEL_FULL    = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MEM_RD = 2'd1,
    S_ACK    = 2'd2
  } wb_state_e;

  typedef enum logic [2:0] {
    R_MEM      = 3'd0,
    R_CTRL     = 3'd1,
    R_STATUS   = 3'd2,
    R_DATALEN  = 3'd3,
    R_UNMAPPED = 3'd4
  } region_e;

  // Lower half of the window is the message memory; registers sit at exact offsets.
  function automatic region_e decode_region(input logic [7:0] off);
    region_e r;
    if (!off[7]) begin
      r = R_MEM;
    end else begin
      case (off)
        OFF_CTRL:    r = R_CTRL;
        OFF_STATUS:  r = R_STATUS;
        OFF_DATALEN: r = R_DATALEN;
        default:     r = R_UNMAPPED;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// Control/status register file: START/IE, sticky DONE/ERR, message length,
// the busy flag that fences off memory access, and the interrupt line.
module wb_regfile
  import ascon_pkg::*;
(
  input  logic        clk,
  input  logic        RST,
  input  logic        wr_en,
  input  region_e     region,
  input  logic [7:0]  wdata,
  input  logic        core_done,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [7:0]  datalen,
  output logic        irq
);

  logic ie;
  logic done;
  logic err;

  logic start;
  logic len_ok;
  logic start_ok;
  logic start_bad;
  logic finish;
  logic w1c_done;
  logic w1c_err;

  always_comb begin
    start     = wr_en && (region == R_CTRL) && wdata[CTRL_START];
    len_ok    = (datalen != 8'd0) && (datalen <= DATALEN_MAX);
    start_ok  = start && !busy && len_ok;
    start_bad = start && !busy && !len_ok;
    finish    = core_done && busy;
    w1c_done  = wr_en && (region == R_STATUS) && wdata[STAT_DONE];
    w1c_err   = wr_en && (region == R_STATUS) && wdata[STAT_ERR];
  end

  // A finishing core outranks a same-cycle W1C so a completion is never lost.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      ie      <= 1'b0;
      datalen <= 8'd0;
    end else begin
      if (start_ok) begin
        busy <= 1'b1;
      end else if (finish) begin
        busy <= 1'b0;
      end

      if (finish) begin
        done <= 1'b1;
      end else if (start_ok || w1c_done) begin
        done <= 1'b0;
      end

      if (start_bad) begin
        err <= 1'b1;
      end else if (start_ok || w1c_err) begin
        err <= 1'b0;
      end

      if (wr_en && (region == R_CTRL)) begin
        ie <= wdata[CTRL_IE];
      end

      if (wr_en && (region == R_DATALEN) && !busy) begin
        datalen <= wdata;
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (region)
      R_CTRL:    rdata[CTRL_IE] = ie;
      R_STATUS: begin
        rdata[STAT_BUSY] = busy;
        rdata[STAT_DONE] = done;
        rdata[STAT_ERR]  = err;
      end
      R_DATALEN: rdata[7:0] = datalen;
      default:   rdata = 32'd0;
    endcase
  end

  assign irq = done & ie;

endmodule

// File: rtl/wb_frontend.sv
// Wishbone classic slave for the ASCON block: decodes a 256-byte window into
// message memory and control registers, and sequences single-cycle acks.
module wb_frontend
  import ascon_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] datain_wb,
  input  logic [31:0] mem_dataout,
  output logic        busy,
  output logic [7:0]  datalen,
  input  logic        core_done,
  output logic        irq,
  output wb_state_e   fsm_state
);

  // Handshake: a request is valid while cyc&stb are high and is taken only
  // in IDLE; the master holds it until wbs_ack_o, which is high for exactly
  // one cycle (the ACK state), after which the FSM is ready again.

  wb_state_e   state;
  wb_state_e   state_nx;
  logic [31:0] offset;
  logic        in_win;
  region_e     region;
  logic        accept;
  logic        is_mem;
  logic        mem_rd_go;
  logic        mem_wr_go;
  logic        reg_wr;
  logic [4:0]  rd_word;
  logic [31:0] reg_rdata;

  always_comb begin
    offset    = wbs_adr_i - BASE_ADDR;
    in_win    = (offset[31:8] == 24'd0);
    region    = decode_region(offset[7:0]);
    accept    = !RST && wbs_cyc_i && wbs_stb_i && in_win && (state == S_IDLE);
    is_mem    = (region == R_MEM);
    mem_rd_go = accept && is_mem && !wbs_we_i && !busy;
    mem_wr_go = accept && is_mem && wbs_we_i && !busy && (wbs_sel_i == SEL_FULL);
    reg_wr    = accept && wbs_we_i && !is_mem;
  end

  always_comb begin
    state_nx  = state;
    wb_we     = 1'b1;
    wb_addr   = 5'd0;
    datain_wb = 32'd0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = mem_rd_go ? S_MEM_RD : S_ACK;
        end
        if (mem_wr_go) begin
          wb_we     = 1'b0;
          wb_addr   = offset[6:2];
          datain_wb = wbs_dat_i;
        end else if (mem_rd_go) begin
          wb_addr = offset[6:2];
        end
      end
      S_MEM_RD: begin
        state_nx = S_ACK;
        wb_addr  = rd_word;
      end
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      rd_word   <= 5'd0;
      wbs_dat_o <= 32'd0;
    end else begin
      state <= state_nx;
      if (mem_rd_go) begin
        rd_word <= offset[6:2];
      end
      // Memory data arrives one cycle after the address; dropped reads return zero.
      if (state == S_MEM_RD) begin
        wbs_dat_o <= mem_dataout;
      end else if (accept && !wbs_we_i && !mem_rd_go) begin
        wbs_dat_o <= is_mem ? 32'd0 : reg_rdata;
      end
    end
  end

  assign wbs_ack_o = (state == S_ACK);
  assign fsm_state = state;

  wb_regfile u_regfile (
    .clk       (clk),
    .RST       (RST),
    .wr_en     (reg_wr),
    .region    (region),
    .wdata     (wbs_dat_i[7:0]),
    .core_done (core_done),
    .rdata     (reg_rdata),
    .busy      (busy),
    .datalen   (datalen),
    .irq       (irq)
  );

endmodule

// File: tb/tb_wb_frontend.sv
// Bench for wb_frontend: vector table of bus accesses, read scoreboard,
// and hand sequences for START/ERR, completion, W1C races and reset aborts.
module tb_wb_frontend;
  import ascon_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk;
  logic        RST;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] datain_wb;
  logic [31:0] mem_dataout;
  logic        busy;
  logic [7:0]  datalen;
  logic        core_done;
  logic        irq;
  wb_state_e   fsm_state;

  wb_frontend #(.BASE_ADDR(BASE)) dut (
    .clk         (clk),
    .RST         (RST),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .datain_wb   (datain_wb),
    .mem_dataout (mem_dataout),
    .busy        (busy),
    .datalen     (datalen),
    .core_done   (core_done),
    .irq         (irq),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory controller model: synchronous write, read data one cycle after address.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      mem_dataout <= 32'd0;
    end else begin
      if (!wb_we) mem[wb_addr] <= datain_wb;
      mem_dataout <= mem[wb_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  logic [31:0] r_rd;
  int          r_lat;
  int          r_strb;
  logic [4:0]  r_acc_addr;
  logic [31:0] r_acc_data;
  logic [4:0]  r_addr2;

  task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic pulse_done);
    bit got;
    got = 0;
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    core_done = pulse_done;
    r_lat = -1; r_strb = 0; r_rd = 32'd0; r_addr2 = 5'd0;
    @(negedge clk);
    r_acc_addr = wb_addr;
    r_acc_data = datain_wb;
    if (!wb_we) r_strb++;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(posedge clk); #1;
      core_done = 1'b0;
      @(negedge clk);
      if (!wb_we) r_strb++;
      if (c == 1) r_addr2 = wb_addr;
      if (wbs_ack_o) begin
        got   = 1;
        r_lat = c;
        r_rd  = wbs_dat_o;
      end
    end
    @(posedge clk); #1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input string name, input logic [7:0] off, input logic [31:0] dat);
    access(1'b1, BASE + 32'(off), dat, 4'hF, 1'b0);
    check({name, "_ack_lat"}, 32'(r_lat), 32'd1);
  endtask

  task automatic rd(input string name, input logic [7:0] off, input logic [31:0] exp, input int lat);
    exp_q.push_back(exp);
    access(1'b0, BASE + 32'(off), 32'd0, 4'hF, 1'b0);
    check({name, "_ack_lat"}, 32'(r_lat), 32'(lat));
    if (exp_q.size() > 0) check({name, "_data"}, r_rd, exp_q.pop_front());
  endtask

  task automatic pulse_core_done();
    @(posedge clk); #1;
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ack"},       32'(wbs_ack_o), 32'd0);
    check({tag, "_dat"},       wbs_dat_o,      32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_datalen"},   32'(datalen),   32'd0);
    check({tag, "_irq"},       32'(irq),       32'd0);
    check({tag, "_wb_we"},     32'(wb_we),     32'd1);
    check({tag, "_wb_addr"},   32'(wb_addr),   32'd0);
    check({tag, "_datain_wb"}, datain_wb,      32'd0);
    check({tag, "_state"},     32'(fsm_state), 32'(S_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_strb;
    logic [4:0]  exp_addr;
  } vec_t;

  vec_t vecs[16];

  initial begin
    RST = 1'b1; core_done = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'd0; wbs_dat_i = 32'd0;

    vecs[0]  = '{1'b1, 8'h08, 32'hA5A5_0001, 4'hF, 32'h0,          1, 1, 5'd2};
    vecs[1]  = '{1'b0, 8'h08, 32'h0,         4'hF, 32'hA5A5_0001, 2, 0, 5'd2};
    vecs[2]  = '{1'b1, 8'h7C, 32'h1234_5678, 4'hF, 32'h0,          1, 1, 5'd31};
    vecs[3]  = '{1'b0, 8'h7C, 32'h0,         4'hF, 32'h1234_5678, 2, 0, 5'd31};
    vecs[4]  = '{1'b1, 8'h10, 32'hDEAD_BEEF, 4'h3, 32'h0,          1, 0, 5'd0};
    vecs[5]  = '{1'b0, 8'h10, 32'h0,         4'hF, 32'h0,          2, 0, 5'd4};
    vecs[6]  = '{1'b1, 8'h88, 32'h0000_0023, 4'hF, 32'h0,          1, 0, 5'd0};
    vecs[7]  = '{1'b0, 8'h88, 32'h0,         4'hF, 32'h0000_0023, 1, 0, 5'd0};
    vecs[8]  = '{1'b1, 8'h80, 32'h0000_0002, 4'hF, 32'h0,          1, 0, 5'd0};
    vecs[9]  = '{1'b0, 8'h80, 32'h0,         4'hF, 32'h0000_0002, 1, 0, 5'd0};
    vecs[10] = '{1'b0, 8'h84, 32'h0,         4'hF, 32'h0,          1, 0, 5'd0};
    vecs[11] = '{1'b1, 8'hC0, 32'hFFFF_FFFF, 4'hF, 32'h0,          1, 0, 5'd0};
    vecs[12] = '{1'b0, 8'hC0, 32'h0,         4'hF, 32'h0,          1, 0, 5'd0};
    vecs[13] = '{1'b0, 8'h8C, 32'h0,         4'hF, 32'h0,          1, 0, 5'd0};
    vecs[14] = '{1'b1, 8'h00, 32'h0BAD_F00D, 4'hF, 32'h0,          1, 1, 5'd0};
    vecs[15] = '{1'b0, 8'h00, 32'h0,         4'hF, 32'h0BAD_F00D, 2, 0, 5'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_held");
    #1 RST = 1'b0;
    @(negedge clk);
    check_reset_values("reset_released");

    for (int i = 0; i < 16; i++) begin
      if (!vecs[i].we) exp_q.push_back(vecs[i].exp_rd);
      access(vecs[i].we, BASE + 32'(vecs[i].off), vecs[i].dat, vecs[i].sel, 1'b0);
      check($sformatf("vec%0d_lat", i), 32'(r_lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_strobes", i), 32'(r_strb), 32'(vecs[i].exp_strb));
      check($sformatf("vec%0d_acc_addr", i), 32'(r_acc_addr), 32'(vecs[i].exp_addr));
      check($sformatf("vec%0d_acc_data", i), r_acc_data,
            (vecs[i].exp_strb != 0) ? vecs[i].dat : 32'd0);
      check($sformatf("vec%0d_addr2", i), 32'(r_addr2),
            (vecs[i].exp_lat == 2) ? 32'(vecs[i].exp_addr) : 32'd0);
      if (!vecs[i].we && exp_q.size() > 0)
        check($sformatf("vec%0d_rdata", i), r_rd, exp_q.pop_front());
    end

    // Out-of-window requests are never acknowledged.
    access(1'b0, BASE + 32'h100, 32'd0, 4'hF, 1'b0);
    check("oow_above_noack", 32'(r_lat), 32'hFFFF_FFFF);
    access(1'b1, BASE - 32'd4, 32'h5555_5555, 4'hF, 1'b0);
    check("oow_below_noack", 32'(r_lat), 32'hFFFF_FFFF);
    check("oow_below_nostrobe", 32'(r_strb), 32'd0);

    // Illegal lengths raise ERR and leave busy low.
    wr("len0_set", 8'h88, 32'h0);
    wr("len0_start", 8'h80, 32'h3);
    check("len0_busy", 32'(busy), 32'd0);
    rd("len0_status", 8'h84, 32'h4, 1);
    wr("len0_w1c", 8'h84, 32'h4);
    rd("len0_status_clr", 8'h84, 32'h0, 1);
    wr("len81_set", 8'h88, 32'h81);
    wr("len81_start", 8'h80, 32'h3);
    check("len81_busy", 32'(busy), 32'd0);
    rd("len81_status", 8'h84, 32'h4, 1);
    wr("len81_w1c", 8'h84, 32'h4);

    // Legal start: memory fenced off while busy.
    wr("len23_set", 8'h88, 32'h23);
    wr("len23_start", 8'h80, 32'h3);
    check("len23_busy", 32'(busy), 32'd1);
    check("len23_err_cleared", 32'(irq), 32'd0);
    access(1'b1, BASE + 32'h08, 32'h1111_1111, 4'hF, 1'b0);
    check("busy_wr_lat", 32'(r_lat), 32'd1);
    check("busy_wr_dropped", 32'(r_strb), 32'd0);
    rd("busy_rd", 8'h08, 32'h0, 1);
    wr("busy_len_wr", 8'h88, 32'h55);
    rd("busy_len_kept", 8'h88, 32'h23, 1);
    wr("busy_restart", 8'h80, 32'h3);
    rd("busy_status", 8'h84, 32'h1, 1);

    // Completion sets DONE and raises irq; W1C drops it.
    pulse_core_done();
    check("done_busy", 32'(busy), 32'd0);
    check("done_irq", 32'(irq), 32'd1);
    rd("done_status", 8'h84, 32'h2, 1);
    wr("done_w1c", 8'h84, 32'h2);
    check("done_irq_clr", 32'(irq), 32'd0);
    pulse_core_done();
    rd("idle_core_done_ignored", 8'h84, 32'h0, 1);
    rd("mem_intact", 8'h08, 32'hA5A5_0001, 2);

    // Length 0x80 is legal; completion racing a DONE W1C leaves DONE set.
    wr("len80_set", 8'h88, 32'h80);
    wr("len80_start", 8'h80, 32'h3);
    check("len80_busy", 32'(busy), 32'd1);
    access(1'b1, BASE + 32'h84, 32'h2, 4'hF, 1'b1);
    check("race_lat", 32'(r_lat), 32'd1);
    check("race_busy", 32'(busy), 32'd0);
    check("race_irq", 32'(irq), 32'd1);
    rd("race_status", 8'h84, 32'h2, 1);

    // Reset while a memory read is in flight.
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE + 32'h08; wbs_sel_i = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_mem_rd", 32'(fsm_state), 32'(S_MEM_RD));
    #1 RST = 1'b1;
    #1 check_reset_values("abort_rst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_noack%0d", c), 32'(wbs_ack_o), 32'd0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #1 RST = 1'b0;
    @(negedge clk);
    check_reset_values("abort_after");

    // Reset while busy.
    wr("rb_len", 8'h88, 32'h10);
    wr("rb_start", 8'h80, 32'h3);
    check("rb_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 RST = 1'b1;
    @(negedge clk);
    check_reset_values("rb_rst");
    #1 RST = 1'b0;
    rd("rb_status", 8'h84, 32'h0, 1);
    rd("rb_ctrl", 8'h80, 32'h0, 1);
    rd("rb_datalen", 8'h88, 32'h0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
